uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among NUM_REQ requesters. Each requester offers a byte with a
//  valid/ready handshake; a round-robin arbiter accepts one byte, launches it with a 1-cycle
//  tx_start and waits for tx_done_tick. An optional inter-frame gap follows before the next grant.
//  Sits between the client ports and the transmitter's tx_start/data_in/tx_done_tick.
// PARAMETERS
//  NUM_REQ        4     number of requesters, 2..16
//  DATA_W         8     payload width; equals transmitter Data_bits-1 (parity added by TX)
//  GAP_CYCLES     2     idle clk cycles between tx_done_tick and next accept; 0 = no gap
//  TIMEOUT_CYCLES 4096  BUSY watchdog limit; used only with UART_ARB_TIMEOUT_EN
// PORTS
//  clk            in   1               system clock
//  Reset          in   1               async, active-high reset
//  req_valid      in   NUM_REQ         per-requester byte offered
//  req_data       in   NUM_REQ*DATA_W  packed bytes; requester i at [i*DATA_W +: DATA_W]
//  req_ready      out  NUM_REQ         one-hot accept; transfer when valid&ready
//  tx_start       out  1               1-cycle launch pulse to transmitter
//  tx_data        out  DATA_W          byte to transmitter, valid while tx_start=1
//  tx_done_tick   in   1               transmitter frame-complete pulse
//  busy           out  1               1 in any state but IDLE
//  grant_id       out  ID_W            id of requester owning the line; ID_W=max(1,$clog2(NUM_REQ))
//  frame_done     out  1               1-cycle pulse, frame for grant_id finished
//  timeout_err    out  1               1-cycle pulse on watchdog expiry (0 when macro off)
// BEHAVIOUR
//  - Clock and reset: clk rising edge; Reset asynchronous, active-high.
//  - Reset values: all outputs 0, FSM IDLE, rr_last=NUM_REQ-1 so requester 0 has first priority.
//  - FSM states: IDLE, LAUNCH, BUSY, GAP.
//  - IDLE: if any req_valid, winner = first valid scanning rr_last+1 .. rr_last (wraps mod NUM_REQ).
//    req_ready[winner]=1 this cycle only (combinational from registered state + req_valid).
//    Latch req_data slice into hold_reg, grant_id<=winner, rr_last<=winner, go to LAUNCH.
//    req_ready is 0 in every other state.
//  - LAUNCH: tx_start=1 and tx_data=hold_reg for exactly 1 cycle, then go to BUSY.
//    Accept-to-tx_start latency is 1 cycle.
//  - BUSY: wait for tx_done_tick, then frame_done=1 for 1 cycle.
//    Next state is GAP if GAP_CYCLES>0, else IDLE.
//  - GAP: counter runs 0..GAP_CYCLES-1, then go to IDLE.
//    Back-to-back worst case: done -> next accept takes GAP_CYCLES+1 cycles.
//  - tx_done_tick outside BUSY (including the LAUNCH cycle) is ignored.
//  - tx_data holds hold_reg at all times; it is meaningful only while tx_start=1.
//  - req_valid dropping before ready: no transfer, no state change. Arbitration is re-evaluated every IDLE cycle.
//  - Fairness: a continuously valid requester waits at most NUM_REQ-1 frames.
//  - Single requester always valid: it is granted every frame.
//  - grant_id holds its value from accept until the next accept; frame_done refers to that id.
//  - Reset mid-frame: FSM returns to IDLE immediately and no frame_done is issued.
//    The transmitter is reset by the same Reset.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined:
//    - BUSY cycle counter, width $clog2(TIMEOUT_CYCLES+1), cleared on entry to BUSY.
//    - When it reaches TIMEOUT_CYCLES with no tx_done_tick: timeout_err=1 for 1 cycle, no frame_done, go to GAP/IDLE per GAP_CYCLES.
//    - tx_done_tick in the same cycle as expiry wins: normal frame_done, no error.
//  UART_ARB_TIMEOUT_EN undefined:
//    - No counter; BUSY waits indefinitely; timeout_err tied to 0.
// TESTING
//  1. Reset with all req_valid=1 -> outputs 0; after release, req_ready=0001 in cycle 1, tx_start in cycle 2, grant_id=0.
//  2. req_valid=1111 held, bytes 0xA0..0xA3, done after 20 cycles each -> grants 0,1,2,3,0; tx_data matches each byte; GAP_CYCLES=2 gap observed.
//  3. Only req 2 valid, GAP_CYCLES=0 -> accept exactly 1 cycle after frame_done; grant_id=2 for every frame.
//  4. tx_done_tick pulsed in IDLE and in LAUNCH -> no frame_done and no state change; first done in BUSY gives frame_done.
//  5. Reset asserted in BUSY -> busy=0 and grant_id=0 immediately; no frame_done; next grant goes to requester 0.
//  6. UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done -> timeout_err 16 cycles after BUSY entry; arbiter resumes granting.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Client/transmitter bundle for the UART TX arbiter.
// slave = arbiter side, master = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_start;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_done_tick;
    logic                      busy;
    logic [ID_W-1:0]           grant_id;
    logic                      frame_done;
    logic                      timeout_err;

    modport slave (
        input  req_valid, req_data, tx_done_tick,
        output req_ready, tx_start, tx_data, busy,
        output grant_id, frame_done, timeout_err
    );

    modport master (
        output req_valid, req_data, tx_done_tick,
        input  req_ready, tx_start, tx_data, busy,
        input  grant_id, frame_done, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Optional BUSY watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic              clk,
    input logic              Reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam int IW1  = ID_W + 1;
    localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST =
        GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE, S_LAUNCH, S_BUSY, S_GAP
    } state_t;

    localparam state_t S_AFTER = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_q, rr_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                start_q, start_d;
    logic [ID_W-1:0]     win;
    logic [IW1-1:0]      idx;
    logic                any_valid;
    logic [NUM_REQ-1:0]  ready;
    logic                fdone;
    logic                terr;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    // Pick the first valid requester scanning from just past the last winner
    always_comb begin
        any_valid = 1'b0;
        win       = '0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = {1'b0, rr_q} + IW1'(k);
            if (idx >= IW1'(NUM_REQ))
                idx = idx - IW1'(NUM_REQ);
            if (bus.req_valid[idx[ID_W-1:0]]) begin
                any_valid = 1'b1;
                win       = idx[ID_W-1:0];
            end
        end
    end

    // Next-state logic: accept, launch, wait for the frame, then idle gap
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        gap_d   = gap_q;
        start_d = 1'b0;
        ready   = '0;
        fdone   = 1'b0;
        terr    = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_valid && !Reset) begin
                    ready[win] = 1'b1;
                    hold_d  = bus.req_data[int'(win)*DATA_W +: DATA_W];
                    grant_d = win;
                    rr_d    = win;
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_BUSY: begin
                if (bus.tx_done_tick) begin
                    fdone   = 1'b1;
                    gap_d   = '0;
                    state_d = S_AFTER;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
                    terr    = 1'b1;
                    gap_d   = '0;
                    state_d = S_AFTER;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = S_IDLE;
                else
                    gap_d = gap_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; requester 0 gets first priority
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            grant_q <= '0;
            rr_q    <= ID_W'(NUM_REQ - 1);
            gap_q   <= '0;
            start_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            gap_q   <= gap_d;
            start_q <= start_d;
`ifdef UART_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.req_ready   = ready;
    assign bus.tx_start    = start_q;
    assign bus.tx_data     = hold_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.grant_id    = grant_q;
    assign bus.frame_done  = fdone;
    assign bus.timeout_err = terr;
endmodule
